// File: rtl/fir_decimator_fifo.sv
// Decimating boxcar averager feeding a show-ahead output FIFO.
// Averages every DECIM accepted samples and queues the result.
module fir_decimator_fifo #(
   parameter int N     = 16,
   parameter int DECIM = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [N-1:0]      data_in,
   input  logic                     in_valid,
   output logic signed [N-1:0]      out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fill_count,
   output logic                     overflow
);

   localparam int LD = $clog2(DECIM);
   localparam int AW = N + LD;
   localparam int PW = $clog2(DEPTH);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum;
   logic [LD-1:0]        phase;
   logic                 last;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 wr_en;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW:0]          count;
   logic signed [N-1:0]  mem [DEPTH];

   assign sum   = acc + {{LD{data_in[N-1]}}, data_in};
   assign last  = (phase == LD'(DECIM - 1));
   assign push  = in_valid && last;
   assign pop   = out_valid && out_ready;
   assign full  = (count == (PW+1)'(DEPTH));
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign wr_en = push && (!full || pop);

   assign out_valid  = (count != '0);
   assign fill_count = count;
   assign out_data   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc   <= '0;
         phase <= '0;
      end else if (in_valid) begin
         if (last) begin
            acc   <= '0;
            phase <= '0;
         end else begin
            acc   <= sum;
            phase <= phase + LD'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (wr_en) begin
         // Floor-shift of the group sum; upper bits are the mean.
         mem[wr_ptr] <= sum[AW-1:LD];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         unique case ({wr_en, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (push && !wr_en)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_decimator_fifo.sv
// Randomized and directed bench for fir_decimator_fifo.
// Reference model: sample groups and FIFO held in queues.
module tb_fir_decimator_fifo;

   localparam int N     = 16;
   localparam int DECIM = 4;
   localparam int DEPTH = 8;

   logic                   clk = 1'b0;
   logic                   reset;
   logic signed [N-1:0]    data_in;
   logic                   in_valid;
   logic signed [N-1:0]    out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] fill_count;
   logic                   overflow;

   int checks = 0;
   int errors = 0;
   int m_q[$];
   int m_grp[$];
   bit m_ovf;

   fir_decimator_fifo #(.N(N), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fill_count (fill_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic int floor_avg(int s);
      int q;
      q = s / DECIM;
      if ((s % DECIM) != 0 && s < 0)
         q = q - 1;
      return q;
   endfunction

   task automatic step(bit v, int d, bit r);
      int  sz;
      int  s;
      bit  pop;
      in_valid  = v;
      data_in   = d[N-1:0];
      out_ready = r;
      sz  = m_q.size();
      pop = r && (sz > 0);
      @(posedge clk);
      if (pop)
         void'(m_q.pop_front());
      if (v) begin
         m_grp.push_back(d);
         if (m_grp.size() == DECIM) begin
            s = 0;
            foreach (m_grp[i])
               s += m_grp[i];
            m_grp.delete();
            if (sz < DEPTH || pop)
               m_q.push_back(floor_avg(s));
            else
               m_ovf = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b0;
      m_q.delete();
      m_grp.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      reset     = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || fill_count !== 0 ||
          overflow !== 1'b0 || out_data !== 0) begin
         errors++;
         $display("FAIL reset: valid=%b fill=%0d ovf=%b data=%0d want 0 0 0 0",
                  out_valid, fill_count, overflow, out_data);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || fill_count !== 0) begin
         errors++;
         $display("FAIL reset_release: valid=%b fill=%0d want 0 0",
                  out_valid, fill_count);
      end
   endtask

   task automatic test_basic();
      logic signed [N-1:0] exp;
      step(1, 4, 0);
      step(1, 8, 0);
      step(1, 12, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early: valid=%b want 0", out_valid);
      end
      step(1, 16, 0);
      checks++;
      if (out_valid !== 1'b1 || fill_count !== 1 || out_data !== 10) begin
         errors++;
         $display("FAIL basic_avg: valid=%b fill=%0d data=%0d want 1 1 10",
                  out_valid, fill_count, out_data);
      end
      step(0, 0, 1);
      checks++;
      if (out_valid !== 1'b0 || fill_count !== 0) begin
         errors++;
         $display("FAIL basic_pop: valid=%b fill=%0d want 0 0",
                  out_valid, fill_count);
      end
      for (int i = 1; i <= 4; i++)
         step(1, -i, 0);
      exp = -3;
      checks++;
      if (out_data !== exp) begin
         errors++;
         $display("FAIL neg_floor: data=%0d want %0d", out_data, exp);
      end
      step(0, 0, 1);
      for (int i = 0; i < 4; i++)
         step(1, 32767, 0);
      for (int i = 0; i < 4; i++)
         step(1, -32768, 0);
      exp = 32767;
      checks++;
      if (fill_count !== 2 || out_data !== exp) begin
         errors++;
         $display("FAIL max_pos: fill=%0d data=%0d want 2 %0d",
                  fill_count, out_data, exp);
      end
      step(0, 0, 1);
      exp = -32768;
      checks++;
      if (fill_count !== 1 || out_data !== exp) begin
         errors++;
         $display("FAIL max_neg: fill=%0d data=%0d want 1 %0d",
                  fill_count, out_data, exp);
      end
      step(0, 0, 1);
   endtask

   task automatic test_gaps();
      step(1, 4, 0);
      repeat (3) step(0, 99, 0);
      step(1, 8, 0);
      step(1, 12, 0);
      step(0, 77, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL gaps_early: valid=%b want 0", out_valid);
      end
      step(1, 16, 0);
      checks++;
      if (fill_count !== 1 || out_data !== 10) begin
         errors++;
         $display("FAIL gaps_avg: fill=%0d data=%0d want 1 10",
                  fill_count, out_data);
      end
      step(0, 0, 1);
   endtask

   task automatic test_overflow();
      repeat (9 * DECIM) step(1, 100, 0);
      checks++;
      if (fill_count !== DEPTH || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_fill: fill=%0d ovf=%b want %0d 1",
                  fill_count, overflow, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 100) begin
            errors++;
            $display("FAIL ovf_drain[%0d]: valid=%b data=%0d want 1 100",
                     i, out_valid, out_data);
         end
         step(0, 0, 1);
      end
      checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: valid=%b ovf=%b want 0 1",
                  out_valid, overflow);
      end
      do_reset();
   endtask

   task automatic test_full_push_pop();
      for (int g = 1; g <= DEPTH; g++)
         repeat (DECIM) step(1, g * 10, 0);
      checks++;
      if (fill_count !== DEPTH || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_fill: fill=%0d ovf=%b want %0d 0",
                  fill_count, overflow, DEPTH);
      end
      repeat (DECIM - 1) step(1, 900, 0);
      step(1, 900, 1);
      checks++;
      if (fill_count !== DEPTH || overflow !== 1'b0 || out_data !== 20) begin
         errors++;
         $display("FAIL full_pushpop: fill=%0d ovf=%b data=%0d want %0d 0 20",
                  fill_count, overflow, out_data, DEPTH);
      end
      for (int i = 2; i <= DEPTH + 1; i++) begin
         checks++;
         if (out_data !== ((i <= DEPTH) ? i * 10 : 900)) begin
            errors++;
            $display("FAIL full_order[%0d]: data=%0d want %0d", i,
                     out_data, (i <= DEPTH) ? i * 10 : 900);
         end
         step(0, 0, 1);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_empty: valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      repeat (3 * DECIM) step(1, 50, 0);
      step(1, 1000, 0);
      step(1, 1000, 0);
      checks++;
      if (fill_count !== 3) begin
         errors++;
         $display("FAIL mid_pre: fill=%0d want 3", fill_count);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (fill_count !== 0 || out_valid !== 1'b0 ||
          out_data !== 0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: fill=%0d valid=%b data=%0d ovf=%b want 0",
                  fill_count, out_valid, out_data, overflow);
      end
      do_reset();
      step(1, 4, 0);
      step(1, 8, 0);
      step(1, 12, 0);
      step(1, 16, 0);
      checks++;
      if (fill_count !== 1 || out_data !== 10) begin
         errors++;
         $display("FAIL mid_after: fill=%0d data=%0d want 1 10",
                  fill_count, out_data);
      end
      step(0, 0, 1);
   endtask

   task automatic test_random();
      int d;
      bit v;
      bit r;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v = ($urandom_range(0, 3) != 0);
         r = (c < 300) ? ($urandom_range(0, 9) < 2)
                       : ($urandom_range(0, 9) < 7);
         d = int'($urandom_range(0, 65535)) - 32768;
         step(v, d, r);
         checks++;
         if (out_valid !== (m_q.size() != 0) ||
             int'(fill_count) != m_q.size() ||
             overflow !== m_ovf ||
             (m_q.size() != 0 && int'(out_data) != m_q[0])) begin
            errors++;
            $display("FAIL random[%0d]: valid=%b fill=%0d ovf=%b data=%0d want %0d %0d %0d",
                     c, out_valid, fill_count, overflow, out_data,
                     m_q.size() != 0, m_q.size(), m_ovf,
                     (m_q.size() != 0) ? m_q[0] : 0);
         end
      end
   endtask

   initial begin
      m_ovf = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_decimator_fifo.md
FIR_DECIMATOR_FIFO -- requirements
Module: fir_decimator_fifo

Interface
REQ-001 SHALL have parameter N, default 16, meaning sample width in bits (two's complement).
REQ-002 SHALL have parameter DECIM, default 4, meaning decimation factor; power of two, 2..16.
REQ-003 SHALL have parameter DEPTH, default 8, meaning output FIFO depth in entries; power of two, 2..32.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 data_in  input  N  signed FIR filter output sample (data_out of FIR_Filter).
REQ-007 in_valid  input  1  data_in holds a sample to consume this cycle.
REQ-008 out_data  output  N  signed decimated sample at FIFO head.
REQ-009 out_valid  output  1  FIFO non-empty; out_data is meaningful.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 fill_count  output  $clog2(DEPTH)+1  number of entries held in the FIFO.
REQ-012 overflow  output  1  sticky flag: a decimated sample was dropped.

Function
REQ-013 SHALL sample in_valid and data_in on every rising clk edge; no input handshake back-pressure (in_valid cannot be stalled).
REQ-014 SHALL hold accumulator acc of width N+log2(DECIM), sign-extending each accepted data_in before addition.
REQ-015 SHALL hold phase counter 0..DECIM-1, incremented only on accepted samples (in_valid=1).
REQ-016 Edge with in_valid=1 and phase<DECIM-1: acc <= acc + data_in; phase <= phase+1.
REQ-017 Edge with in_valid=1 and phase=DECIM-1: result = (acc + data_in) arithmetic-shifted right by log2(DECIM) (floor rounding), truncated to N bits; push result; acc <= 0; phase <= 0.
REQ-018 Edge with in_valid=0: acc and phase unchanged.
REQ-019 Averaged result SHALL never overflow N bits (mean of N-bit values); no saturation logic required.
REQ-020 FIFO SHALL be first-in first-out, circular read/write pointers wrapping at DEPTH.
REQ-021 Pop occurs on an edge where out_valid=1 and out_ready=1; out_ready while empty is ignored.
REQ-022 out_valid SHALL equal (fill_count != 0); out_data SHALL present head entry combinationally from storage (show-ahead).
REQ-023 Latency: result pushed at edge k SHALL appear on out_data/out_valid after edge k when FIFO was empty; no same-cycle bypass.
REQ-024 Push with FIFO full and no pop on same edge: sample dropped, FIFO unchanged, overflow <= 1.
REQ-025 Push and pop on same edge: both performed, fill_count unchanged, including when full (no drop, no overflow).
REQ-026 overflow SHALL remain 1 until reset; no other clear path.
REQ-027 out_data while out_valid=0 is don't-care but SHALL not be X after reset (storage reset to 0).

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) force acc=0, phase=0, read/write pointers=0, fill_count=0, out_valid=0, overflow=0, out_data=0.
REQ-029 Deassertion SHALL take effect at the first rising clk edge with reset=1; partially accumulated group lost on reset mid-operation.

Verification
REQ-030 DECIM=4: in_valid=1 with 4, 8, 12, 16 -> one push of 10; out_valid=1 after 4th edge, fill_count=1.
REQ-031 Inputs -1, -2, -3, -4 -> out_data = -3 (sum -10, floor shift); inputs 32767 x4 -> 32767; -32768 x4 -> -32768.
REQ-032 in_valid gaps: 4, idle 3 cycles, 8, 12, idle, 16 -> single output 10, identical to REQ-030.
REQ-033 out_ready=0, 9 groups of four 100s -> fill_count=8, overflow=1, 8 entries of 100; drain with out_ready=1 -> 8 pops then out_valid=0, overflow still 1.
REQ-034 FIFO full, group completes on edge with out_ready=1 -> fill_count stays 8, overflow stays 0, new sample at tail.
REQ-035 reset=0 pulsed after 2 of 4 samples (FIFO holding 3) -> outputs zero at once; next 4 inputs 4,8,12,16 -> single output 10, fill_count=1.
